// File: rtl/stack_frame_ctrl.sv
// stack_frame_ctrl: sequences ENTER/LEAVE/LEAVE_RESULT into operand-stack ops and keeps saved frame limits.
// Optional STACK_FRAME_PASSTHRU_EN adds a user op pass-through port used while idle.
module stack_frame_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 7,
  parameter int FRAMES = 8
)(
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_cmd_valid,
  output logic                         o_cmd_ready,
  input  logic [1:0]                   i_cmd,
  input  logic [DEPTH:0]               i_cmd_args,
  output logic                         o_done,
  output logic [1:0]                   o_done_status,
  output logic [$clog2(FRAMES+1)-1:0]  o_frame_depth,
  output logic [2:0]                   o_stk_op,
  output logic [WIDTH-1:0]             o_stk_data,
  output logic [DEPTH:0]               o_stk_underflow_limit,
`ifdef STACK_FRAME_PASSTHRU_EN
  input  logic [2:0]                   i_user_op,
  input  logic [WIDTH-1:0]             i_user_data,
  output logic                         o_user_ready,
`endif
  input  logic [DEPTH:0]               i_stk_index,
  input  logic [WIDTH-1:0]             i_stk_tos,
  input  logic [2:0]                   i_stk_status
);
  localparam int FW = $clog2(FRAMES+1);
  localparam logic [FW-1:0] MAX_FRAMES = FRAMES[FW-1:0];
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_SYNC = 2'd3;
  localparam logic [1:0] C_NOP = 2'd0, C_ENTER = 2'd1, C_LRES = 2'd3;
  localparam logic [1:0] ST_OK = 2'd0, ST_OVF = 2'd1, ST_UNF = 2'd2, ST_ERR = 2'd3;
  localparam logic [2:0] OP_NONE = 3'd0, OP_UF_RESET = 3'd4, OP_UF_PUSH = 3'd5;
  localparam logic [2:0] SS_OVERFLOW = 3'd3, SS_UNDERFLOW = 3'd4, SS_UNKNOWN = 3'd5;

  logic [1:0]       r_state, r_cmd, r_status;
  logic [DEPTH:0]   r_limit;
  logic [FW-1:0]    r_depth;
  logic [WIDTH-1:0] r_result;
  logic [DEPTH:0]   r_store [0:FRAMES-1];
  logic [DEPTH+1:0] w_diff;
  logic             w_enter_err, w_stk_fail;

  // new base is computed one bit wider so args > index shows up as a negative result
  assign w_diff      = {1'b0, i_stk_index} - {1'b0, i_cmd_args};
  assign w_enter_err = w_diff[DEPTH+1] || (w_diff[DEPTH:0] < r_limit);
  assign w_stk_fail  = i_stk_status == SS_OVERFLOW || i_stk_status == SS_UNDERFLOW || i_stk_status == SS_UNKNOWN;

  assign o_cmd_ready           = r_state == S_IDLE;
  assign o_done                = r_state == S_SYNC;
  assign o_done_status         = r_status;
  assign o_frame_depth         = r_depth;
  assign o_stk_underflow_limit = r_limit;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_cmd    <= C_NOP;
      r_status <= ST_OK;
      r_limit  <= '0;
      r_depth  <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_cmd_valid) begin
          r_cmd    <= i_cmd;
          r_result <= i_stk_tos;
          r_status <= ST_OK;
          r_state  <= S_SYNC;
          if (i_cmd == C_ENTER) begin
            if (r_depth == MAX_FRAMES) r_status <= ST_OVF;
            else if (w_enter_err) r_status <= ST_ERR;
            else begin
              r_store[r_depth] <= r_limit;
              r_limit <= w_diff[DEPTH:0];
              r_depth <= r_depth + 1'b1;
              r_state <= S_ISSUE;
            end
          end else if (i_cmd != C_NOP) begin
            if (r_depth == '0) r_status <= ST_UNF;
            else if (i_cmd == C_LRES && i_stk_index <= r_limit) r_status <= ST_ERR;
            else r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= r_cmd == C_ENTER ? S_SYNC : S_WAIT;
        S_WAIT: begin
          r_limit  <= r_store[r_depth - 1'b1];
          r_depth  <= r_depth - 1'b1;
          r_status <= w_stk_fail ? ST_ERR : ST_OK;
          r_state  <= S_SYNC;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_stk_op   = OP_NONE;
    o_stk_data = '0;
    if (r_state == S_ISSUE && r_cmd != C_ENTER) begin
      o_stk_op   = r_cmd == C_LRES ? OP_UF_PUSH : OP_UF_RESET;
      o_stk_data = r_cmd == C_LRES ? r_result : '0;
    end
`ifdef STACK_FRAME_PASSTHRU_EN
    o_user_ready = r_state == S_IDLE && !i_cmd_valid;
    if (o_user_ready) begin
      o_stk_op   = i_user_op;
      o_stk_data = i_user_data;
    end
`endif
  end
endmodule
